// File: rtl/scroll_register_bank.sv
// Bus-decoded scroll X/Y and priority registers for four tilemap layers.
// Define SCROLL_DBUF_EN to double-buffer through shadow registers committed on VBLANK entry.
module scroll_register_bank #(
    parameter logic [8:0] X_OFFSET  = 9'd0,
    parameter logic [2:0] PRI_RESET = 3'd0
) (
    input  logic        CLK_6M,
    input  logic        nRESET,
    input  logic        CLK_2H,
    input  logic        nVBLANK,
    input  logic [12:0] A,
    input  logic [7:0]  D,
    input  logic        nWE,
    input  logic        nSCROLL0,
    input  logic        nSCROLL1,
    output logic [35:0] SCRX,
    output logic [31:0] SCRY,
    output logic [11:0] PRI,
    output logic        UPDATED
);

    logic       wq;
    logic       commit;
    logic [1:0] layer;
    logic       wq_d_q, wq_d_d;
    logic       updated_q, updated_d;

    logic [8:0] act_x_q [4];
    logic [8:0] act_x_d [4];
    logic [7:0] act_y_q [4];
    logic [7:0] act_y_d [4];
    logic [2:0] act_pri_q [4];
    logic [2:0] act_pri_d [4];

    logic [8:0] wr_x [4];
    logic [7:0] wr_y [4];
    logic [2:0] wr_pri [4];

`ifdef SCROLL_DBUF_EN
    logic       nvblank_d_q, nvblank_d_d;
    logic       vblank_entry;
    logic [8:0] shd_x_q [4];
    logic [8:0] shd_x_d [4];
    logic [7:0] shd_y_q [4];
    logic [7:0] shd_y_d [4];
    logic [2:0] shd_pri_q [4];
    logic [2:0] shd_pri_d [4];
`endif

    // Exactly one select low qualifies a write; both low is a bus conflict and is dropped.
    always_comb begin
        wq     = CLK_2H & ~nWE & (nSCROLL0 ^ nSCROLL1);
        commit = wq & ~wq_d_q;
        layer  = {nSCROLL0, A[2]};
        wq_d_d = wq;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
`ifdef SCROLL_DBUF_EN
            wr_x[i]   = shd_x_q[i];
            wr_y[i]   = shd_y_q[i];
            wr_pri[i] = shd_pri_q[i];
`else
            wr_x[i]   = act_x_q[i];
            wr_y[i]   = act_y_q[i];
            wr_pri[i] = act_pri_q[i];
`endif
        end
        if (commit) begin
            case (A[1:0])
                2'b00: begin
                    wr_x[layer][8] = D[0];
                    wr_pri[layer]  = D[3:1];
                end
                2'b01:   wr_x[layer][7:0] = D;
                2'b10:   wr_y[layer]      = D;
                default: ;
            endcase
        end
    end

    // Active set is loaded from the pre-write shadow, so a colliding write waits a frame.
    always_comb begin
`ifdef SCROLL_DBUF_EN
        nvblank_d_d  = nVBLANK;
        vblank_entry = nvblank_d_q & ~nVBLANK;
        shd_x_d      = wr_x;
        shd_y_d      = wr_y;
        shd_pri_d    = wr_pri;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_pri_d    = act_pri_q;
        if (vblank_entry) begin
            act_x_d   = shd_x_q;
            act_y_d   = shd_y_q;
            act_pri_d = shd_pri_q;
        end
        updated_d = vblank_entry;
`else
        act_x_d   = wr_x;
        act_y_d   = wr_y;
        act_pri_d = wr_pri;
        updated_d = commit;
`endif
    end

    always_ff @(posedge CLK_6M or negedge nRESET) begin
        if (!nRESET) begin
            wq_d_q    <= 1'b0;
            updated_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                act_x_q[i]   <= '0;
                act_y_q[i]   <= '0;
                act_pri_q[i] <= PRI_RESET;
            end
        end else begin
            wq_d_q    <= wq_d_d;
            updated_q <= updated_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            act_pri_q <= act_pri_d;
        end
    end

`ifdef SCROLL_DBUF_EN
    always_ff @(posedge CLK_6M or negedge nRESET) begin
        if (!nRESET) begin
            nvblank_d_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shd_x_q[i]   <= '0;
                shd_y_q[i]   <= '0;
                shd_pri_q[i] <= PRI_RESET;
            end
        end else begin
            nvblank_d_q <= nvblank_d_d;
            shd_x_q     <= shd_x_d;
            shd_y_q     <= shd_y_d;
            shd_pri_q   <= shd_pri_d;
        end
    end
`endif

    always_comb begin
        SCRX = '0;
        SCRY = '0;
        PRI  = '0;
        for (int i = 0; i < 4; i++) begin
            SCRX[9*i +: 9] = act_x_q[i] + X_OFFSET;
            SCRY[8*i +: 8] = act_y_q[i];
            PRI[3*i +: 3]  = act_pri_q[i];
        end
        UPDATED = updated_q;
    end

    logic unused_bus;
`ifdef SCROLL_DBUF_EN
    assign unused_bus = ^A[12:3];
`else
    assign unused_bus = ^{A[12:3], nVBLANK};
`endif

endmodule
